// File: rtl/fifo_pkt_tx.sv
// Read-side packetizer for the dual-clock sample FIFO.
// Commits a packet once PKT_WORDS words are buffered, then streams it out.
module fifo_pkt_tx #(
    parameter int DATA_W    = 64,
    parameter int USEDW_W   = 10,
    parameter int PKT_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic [USEDW_W-1:0] fifo_rdusedw,
    input  logic              fifo_rdempty,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_startofpacket,
    output logic              tx_endofpacket,
    output logic [2:0]        tx_empty,
    output logic [31:0]       pkt_count,
    output logic              busy
);

    localparam int CW = USEDW_W + 1;
    localparam logic [CW-1:0] PKT_N    = CW'(PKT_WORDS);
    localparam logic [CW-1:0] PKT_LAST = CW'(PKT_WORDS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     fetch_cnt;
    logic [CW-1:0]     cap_cnt;
    logic              inflight;
    logic [1:0]        occ;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [DATA_W-1:0] buf_d [0:2];
    logic [2:0]        buf_sop;
    logic [2:0]        buf_eop;

    logic threshold;
    logic room;
    logic push;
    logic pop;
    logic eop_pop;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign threshold = {1'b0, fifo_rdusedw} >= PKT_N;

    // Reserve a slot for the word still in flight from the FIFO.
    assign room = ({1'b0, occ} + {2'b00, inflight}) < 3'd3;

    assign fifo_rdreq = (state == S_FETCH)
                      && !fifo_rdempty
                      && room
                      && (fetch_cnt < PKT_N);

    assign push    = inflight;
    assign tx_valid = (occ != 2'd0);
    assign pop     = tx_valid && tx_ready;
    assign eop_pop = pop && buf_eop[rd_ptr];

    assign tx_data          = tx_valid ? buf_d[rd_ptr] : '0;
    assign tx_startofpacket = tx_valid && buf_sop[rd_ptr];
    assign tx_endofpacket   = tx_valid && buf_eop[rd_ptr];
    assign tx_empty         = 3'd0;

    // Skid buffer: data has no reset, occupancy alone marks it stale.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_d[wr_ptr] <= fifo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            buf_sop  <= 3'b000;
            buf_eop  <= 3'b000;
        end else begin
            inflight <= fifo_rdreq;
            if (push) begin
                buf_sop[wr_ptr] <= (cap_cnt == '0);
                buf_eop[wr_ptr] <= (cap_cnt == PKT_LAST);
                wr_ptr          <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            fetch_cnt <= '0;
            cap_cnt   <= '0;
            pkt_count <= 32'd0;
            busy      <= 1'b0;
        end else begin
            if (push) begin
                cap_cnt <= cap_cnt + CNT_ONE;
            end
            case (state)
                S_IDLE: begin
                    if (threshold) begin
                        state     <= S_FETCH;
                        fetch_cnt <= '0;
                        cap_cnt   <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fifo_rdreq) begin
                        fetch_cnt <= fetch_cnt + CNT_ONE;
                        if (fetch_cnt == PKT_LAST) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (eop_pop) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        pkt_count <= pkt_count + 32'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
